dmem_lsu: RTL and testbench
===========================

# dmem_lsu

Load/store unit that initiates every data-memory access for the core. It accepts one load or store request at a time from the execute stage over a valid/ready handshake and drives the data memory's byte-address, write-data, `mem_read` and `mem_write` pins. Sub-doubleword stores are done as read-modify-write against the 64-bit memory entries. It returns a sign- or zero-extended load result, or a store completion, over a valid/ready response channel.

## Interface
- `DMEM_ADDR_WIDTH`, default 10: byte-address width of the data memory.
- `clk`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  unit can accept a request.
- `req_we`  in  1  1 = store, 0 = load.
- `req_funct3`  in  3  RISC-V funct3 (size/sign).
- `req_addr`  in  DMEM_ADDR_WIDTH  byte address.
- `req_wdata`  in  64  store data; the operand is in the low bits.
- `resp_valid`  out  1  response present.
- `resp_ready`  in  1  consumer takes the response.
- `resp_rdata`  out  64  extended load data; 0 for stores.
- `resp_err`  out  1  request rejected (misaligned or illegal funct3).
- `mem_addr`  out  DMEM_ADDR_WIDTH  doubleword-aligned byte address (`[2:0]` = 0).
- `mem_din`  out  64  write data to memory.
- `mem_read`  out  1  read enable; memory data is combinational in the same cycle.
- `mem_write`  out  1  write enable; memory captures on the next rising edge.
- `mem_dout`  in  64  memory read data.

## Operation
- **States:** IDLE, ACCESS, WRITE, RESP.
- **IDLE**
  - `req_ready`=1.
  - On `req_valid`: register `we`, `funct3`, `addr` and `wdata`.
  - Go to RESP with err=1 if the request is illegal. Otherwise go to ACCESS.
- **Legality**
  - Loads: funct3 111 is illegal.
  - Stores: funct3 1xx is illegal.
  - Misaligned is illegal: `addr[0]`≠0 for half, `addr[1:0]`≠0 for word, `addr[2:0]`≠0 for double.
- **Byte offset:** off = `addr[2:0]`.
- **ACCESS**
  - Load:
    - `mem_read`=1.
    - Extract the operand at byte offset off×8 from `mem_dout`.
    - Sign-extend for 000/001/010; zero-extend for 100/101/110; 011 passes all 64 bits.
    - Register the result and go to RESP.
  - Store with funct3 011: `mem_write`=1, `mem_din`=wdata, then go to RESP.
  - Store sb/sh/sw:
    - `mem_read`=1.
    - Merge the low 8/16/32 bits of wdata into `mem_dout` at off×8.
    - Register the merged value and go to WRITE.
- **WRITE:** `mem_write`=1, `mem_din`=merged value, then go to RESP.
- **RESP**
  - `resp_valid`=1; `resp_rdata` and `resp_err` are held stable.
  - Leave for IDLE when `resp_ready`=1.
- **Memory-pin rules**
  - `mem_addr` = {`addr[W-1:3]`,3'b000} in ACCESS and WRITE, else 0.
  - `mem_din` is 0 except on a write cycle.
  - `mem_read` and `mem_write` are never both 1.
  - `mem_read` and `mem_write` are 0 in IDLE and RESP.
- **Rejected requests** produce no memory activity.

## Timing
- **Reset:**
  - state=IDLE.
  - `req_ready`=0 during the reset cycle, 1 from the first cycle after.
  - `resp_valid`, `resp_err`, `resp_rdata`, `mem_*` outputs all 0.
  - Registered request fields are cleared.
- **Accept edge T** (`req_valid`&`req_ready`):
  - Load or sd: ACCESS in T+1, `resp_valid` from T+2.
  - sb/sh/sw: ACCESS in T+1, WRITE in T+2, `resp_valid` from T+3.
  - Illegal: `resp_valid` from T+1.
- **Throughput:** a new request is accepted no earlier than the cycle after the response handshake; no overlap, no bypass.
- **Backpressure:** `resp_valid` stays high with stable data for any number of `resp_ready`=0 cycles.
- **Reset mid-operation**
  - Reset wins: the next state is IDLE and outputs go to reset values.
  - A reset asserted in ACCESS or WRITE still lets the memory see that cycle's `mem_write`, since the write commits on the same edge.
  - No further writes occur after the reset edge.
- **Simultaneous `req_valid` in RESP:** ignored (`req_ready`=0).

## Configuration
- Macro: `DMEM_LSU_MISALIGN_TRAP_EN`.
- **Defined:** misaligned requests are rejected as above (`resp_err`=1, no memory access).
- **Undefined:**
  - Misaligned requests are force-aligned by clearing the offending low address bits: half `[0]`, word `[1:0]`, double `[2:0]`.
  - The access then proceeds normally.
  - `resp_err` is set only for illegal funct3.

## Test plan
- Memory entry 2 = 64'h8877665544332211; ld funct3 011, addr 16 -> `resp_rdata`=64'h8877665544332211 at T+2, `mem_read`=1 in T+1 only.
- Entry 1 = 64'h00000000000080F0; lb addr 8 -> 64'hFFFFFFFFFFFFFFF0; lbu addr 9 -> 64'h80; lh addr 8 -> 64'hFFFFFFFFFFFF80F0.
- Entry 0 = 64'h1111111111111111; sh wdata 64'hABCD, addr 2 -> `mem_read` in T+1, `mem_write` in T+2 with `mem_din`=64'h11111111ABCD1111, `resp_valid` at T+3.
- lw addr 6 with the macro defined -> `resp_err`=1 at T+1, `mem_read`=`mem_write`=0 throughout. Same request with the macro undefined -> reads the word at offset 4.
- Load response held with `resp_ready`=0 for 5 cycles -> `resp_valid` and data stable, `req_ready`=0. Release -> IDLE the next cycle.
- Reset asserted during ACCESS of an sb -> no `mem_write` after the reset edge, entry unchanged, all outputs 0, `req_ready`=1 one cycle after reset drops.

Source files
------------

// File: rtl/dmem_lsu.sv
// dmem_lsu: single-outstanding load/store unit with read-modify-write for sub-doubleword stores.
// Build option DMEM_LSU_MISALIGN_TRAP_EN: defined rejects misaligned requests, undefined force-aligns them.

module dmem_lsu #(
  parameter int DMEM_ADDR_WIDTH = 10
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       req_valid_i,
  output logic                       req_ready_o,
  input  logic                       req_we_i,
  input  logic [2:0]                 req_funct3_i,
  input  logic [DMEM_ADDR_WIDTH-1:0] req_addr_i,
  input  logic [63:0]                req_wdata_i,
  output logic                       resp_valid_o,
  input  logic                       resp_ready_i,
  output logic [63:0]                resp_rdata_o,
  output logic                       resp_err_o,
  output logic [DMEM_ADDR_WIDTH-1:0] mem_addr_o,
  output logic [63:0]                mem_din_o,
  output logic                       mem_read_o,
  output logic                       mem_write_o,
  input  logic [63:0]                mem_dout_i
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_WRITE  = 2'd2;
  localparam logic [1:0] ST_RESP   = 2'd3;

  function automatic logic f3_illegal(input logic we, input logic [2:0] f3);
    logic bad;
    if (we) begin
      bad = f3[2];
    end else begin
      bad = (f3 == 3'b111);
    end
    return bad;
  endfunction

`ifdef DMEM_LSU_MISALIGN_TRAP_EN
  function automatic logic misaligned(input logic [2:0] f3, input logic [2:0] lo);
    logic mis;
    case (f3[1:0])
      2'b01:   mis = lo[0];
      2'b10:   mis = |lo[1:0];
      2'b11:   mis = |lo;
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction
`else
  function automatic logic [DMEM_ADDR_WIDTH-1:0] force_align(input logic [2:0] f3,
                                                            input logic [DMEM_ADDR_WIDTH-1:0] addr);
    logic [DMEM_ADDR_WIDTH-1:0] a;
    a = addr;
    case (f3[1:0])
      2'b01:   a[0]   = 1'b0;
      2'b10:   a[1:0] = 2'b00;
      2'b11:   a[2:0] = 3'b000;
      default: a      = addr;
    endcase
    return a;
  endfunction
`endif

  function automatic logic [63:0] load_extend(input logic [2:0] f3, input logic [63:0] dout,
                                              input logic [2:0] off);
    logic [63:0] sh;
    logic [63:0] res;
    sh = dout >> {off, 3'b000};
    case (f3)
      3'b000:  res = {{56{sh[7]}}, sh[7:0]};
      3'b001:  res = {{48{sh[15]}}, sh[15:0]};
      3'b010:  res = {{32{sh[31]}}, sh[31:0]};
      3'b011:  res = dout;
      3'b100:  res = {56'd0, sh[7:0]};
      3'b101:  res = {48'd0, sh[15:0]};
      3'b110:  res = {32'd0, sh[31:0]};
      default: res = 64'd0;
    endcase
    return res;
  endfunction

  function automatic logic [63:0] store_merge(input logic [2:0] f3, input logic [63:0] dout,
                                              input logic [63:0] wdata, input logic [2:0] off);
    logic [63:0] base;
    logic [5:0]  amt;
    amt = {off, 3'b000};
    case (f3[1:0])
      2'b00:   base = 64'h0000_0000_0000_00FF;
      2'b01:   base = 64'h0000_0000_0000_FFFF;
      2'b10:   base = 64'h0000_0000_FFFF_FFFF;
      default: base = 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
    return (dout & ~(base << amt)) | ((wdata & base) << amt);
  endfunction

  logic [1:0]                 state_q, state_d;
  logic                       we_q, we_d;
  logic [2:0]                 funct3_q, funct3_d;
  logic [DMEM_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [63:0]                wdata_q, wdata_d;
  logic [63:0]                merged_q, merged_d;
  logic [63:0]                rdata_q, rdata_d;
  logic                       err_q, err_d;

  logic                       req_err_s;
  logic [DMEM_ADDR_WIDTH-1:0] req_addr_s;
  logic                       is_sd_s;
  logic [DMEM_ADDR_WIDTH-1:0] dw_addr_s;

  always_comb begin
`ifdef DMEM_LSU_MISALIGN_TRAP_EN
    req_err_s  = f3_illegal(req_we_i, req_funct3_i) | misaligned(req_funct3_i, req_addr_i[2:0]);
    req_addr_s = req_addr_i;
`else
    req_err_s  = f3_illegal(req_we_i, req_funct3_i);
    req_addr_s = force_align(req_funct3_i, req_addr_i);
`endif
    is_sd_s   = we_q && (funct3_q[1:0] == 2'b11);
    dw_addr_s = {addr_q[DMEM_ADDR_WIDTH-1:3], 3'b000};
  end

  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    funct3_d = funct3_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    merged_d = merged_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid_i) begin
          we_d     = req_we_i;
          funct3_d = req_funct3_i;
          addr_d   = req_addr_s;
          wdata_d  = req_wdata_i;
          rdata_d  = 64'd0;
          err_d    = req_err_s;
          state_d  = req_err_s ? ST_RESP : ST_ACCESS;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        if (!we_q) begin
          rdata_d = load_extend(funct3_q, mem_dout_i, addr_q[2:0]);
          state_d = ST_RESP;
        end else if (is_sd_s) begin
          state_d = ST_RESP;
        end else begin
          merged_d = store_merge(funct3_q, mem_dout_i, wdata_q, addr_q[2:0]);
          state_d  = ST_WRITE;
        end
      end
      ST_WRITE: state_d = ST_RESP;
      ST_RESP: begin
        if (resp_ready_i) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= ST_IDLE;
      we_q     <= 1'b0;
      funct3_q <= 3'd0;
      addr_q   <= {DMEM_ADDR_WIDTH{1'b0}};
      wdata_q  <= 64'd0;
      merged_q <= 64'd0;
      rdata_q  <= 64'd0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      funct3_q <= funct3_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      merged_q <= merged_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  // Memory pins are pure state decode, so a write in flight at reset still reaches the memory.
  always_comb begin
    req_ready_o  = (state_q == ST_IDLE) && !reset_i;
    resp_valid_o = (state_q == ST_RESP);
    resp_rdata_o = rdata_q;
    resp_err_o   = err_q;
    mem_addr_o   = {DMEM_ADDR_WIDTH{1'b0}};
    mem_din_o    = 64'd0;
    mem_read_o   = 1'b0;
    mem_write_o  = 1'b0;
    case (state_q)
      ST_ACCESS: begin
        mem_addr_o = dw_addr_s;
        if (is_sd_s) begin
          mem_write_o = 1'b1;
          mem_din_o   = wdata_q;
        end else begin
          mem_read_o = 1'b1;
        end
      end
      ST_WRITE: begin
        mem_addr_o  = dw_addr_s;
        mem_write_o = 1'b1;
        mem_din_o   = merged_q;
      end
      default: begin
        mem_addr_o = {DMEM_ADDR_WIDTH{1'b0}};
      end
    endcase
  end

endmodule

// File: tb/tb_dmem_lsu.sv
// Randomized bench for dmem_lsu: byte-level reference model plus per-cycle pin expectations.
module tb_dmem_lsu;
  localparam int W    = 10;
  localparam int NENT = 1 << (W - 3);

  logic          clk_i = 1'b0;
  logic          reset_i;
  logic          req_valid_i, req_ready_o, req_we_i;
  logic [2:0]    req_funct3_i;
  logic [W-1:0]  req_addr_i;
  logic [63:0]   req_wdata_i;
  logic          resp_valid_o, resp_ready_i;
  logic [63:0]   resp_rdata_o;
  logic          resp_err_o;
  logic [W-1:0]  mem_addr_o;
  logic [63:0]   mem_din_o, mem_dout_i;
  logic          mem_read_o, mem_write_o;

  logic [63:0] mem_arr [NENT];
  logic [63:0] mdl [NENT];

  int n_chk = 0;
  int n_pass = 0;

  logic        chk_en = 1'b0;
  logic        e_req_ready, e_resp_valid, e_mem_read, e_mem_write, e_chk_resp, e_err;
  logic [63:0] e_mem_addr, e_mem_din, e_rdata;

  dmem_lsu #(.DMEM_ADDR_WIDTH(W)) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
    .req_funct3_i(req_funct3_i), .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
    .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
    .resp_rdata_o(resp_rdata_o), .resp_err_o(resp_err_o),
    .mem_addr_o(mem_addr_o), .mem_din_o(mem_din_o), .mem_read_o(mem_read_o),
    .mem_write_o(mem_write_o), .mem_dout_i(mem_dout_i)
  );

  always #5 clk_i = ~clk_i;

  assign mem_dout_i = mem_arr[mem_addr_o[W-1:3]];

  always @(posedge clk_i) begin
    if (mem_write_o) mem_arr[mem_addr_o[W-1:3]] <= mem_din_o;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  always @(negedge clk_i) begin
    if (chk_en) begin
      chk("req_ready", 64'(req_ready_o), 64'(e_req_ready));
      chk("resp_valid", 64'(resp_valid_o), 64'(e_resp_valid));
      chk("mem_read", 64'(mem_read_o), 64'(e_mem_read));
      chk("mem_write", 64'(mem_write_o), 64'(e_mem_write));
      chk("mem_addr", 64'(mem_addr_o), e_mem_addr);
      chk("mem_din", mem_din_o, e_mem_din);
      if (e_chk_resp) begin
        chk("resp_rdata", resp_rdata_o, e_rdata);
        chk("resp_err", 64'(resp_err_o), 64'(e_err));
      end
    end
  end

  function automatic logic [63:0] mdl_load(input logic [2:0] f3, input logic [63:0] entry, input int off);
    int n;
    logic [63:0] v;
    n = 1 << f3[1:0];
    v = 64'd0;
    for (int i = 0; i < n; i++) v[i*8 +: 8] = entry[(off+i)*8 +: 8];
    if (!f3[2] && n < 8 && v[n*8-1]) begin
      for (int i = n * 8; i < 64; i++) v[i] = 1'b1;
    end
    return v;
  endfunction

  function automatic logic [63:0] mdl_store(input logic [2:0] f3, input logic [63:0] entry,
                                            input logic [63:0] wdata, input int off);
    int n;
    logic [63:0] e;
    n = 1 << f3[1:0];
    e = entry;
    for (int i = 0; i < n; i++) e[(off+i)*8 +: 8] = wdata[i*8 +: 8];
    return e;
  endfunction

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic exp_quiet(input logic rdy);
    e_req_ready  = rdy;
    e_resp_valid = 1'b0;
    e_mem_read   = 1'b0;
    e_mem_write  = 1'b0;
    e_mem_addr   = 64'd0;
    e_mem_din    = 64'd0;
    e_chk_resp   = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      req_valid_i  = 1'b0;
      resp_ready_i = 1'($urandom_range(0, 1));
      exp_quiet(1'b1);
    end
  endtask

  // lit_kind: 0 none, 1 check resp_rdata in first response cycle, 2 check mem_din in the write cycle
  task automatic run_txn(input logic we, input logic [2:0] f3, input logic [W-1:0] addr,
                         input logic [63:0] wdata, input int stall, input int rst_at,
                         input int lit_kind, input logic [63:0] lit);
    int n, idx, off, nacc;
    logic bad_f3, mis, err;
    logic [W-1:0] ea;
    logic [63:0] exp_rd, new_e;
    bad_f3 = we ? f3[2] : (f3 == 3'd7);
    n   = 1 << f3[1:0];
    mis = (int'(addr) % n) != 0;
    ea  = addr;
`ifdef DMEM_LSU_MISALIGN_TRAP_EN
    err = bad_f3 || mis;
`else
    err = bad_f3;
    ea  = addr - W'(int'(addr) % n);
`endif
    idx    = int'(ea) / 8;
    off    = int'(ea) % 8;
    exp_rd = 64'd0;
    new_e  = mdl[idx];
    if (!err && !we) exp_rd = mdl_load(f3, mdl[idx], off);
    if (!err && we) new_e = mdl_store(f3, mdl[idx], wdata, off);
    nacc = err ? 0 : ((we && n < 8) ? 2 : 1);

    step();
    req_valid_i  = 1'b1;
    req_we_i     = we;
    req_funct3_i = f3;
    req_addr_i   = addr;
    req_wdata_i  = wdata;
    resp_ready_i = 1'($urandom_range(0, 1));
    exp_quiet(1'b1);

    for (int c = 1; c <= nacc; c++) begin
      step();
      req_valid_i  = 1'($urandom_range(0, 1));
      req_addr_i   = W'($urandom);
      resp_ready_i = 1'($urandom_range(0, 1));
      exp_quiet(1'b0);
      e_mem_addr = 64'(idx * 8);
      if (we && c == nacc) begin
        e_mem_write = 1'b1;
        e_mem_din   = new_e;
        mdl[idx]    = new_e;
        if (lit_kind == 2) begin
          #1;
          chk("lit_mem_din", mem_din_o, lit);
        end
      end else begin
        e_mem_read = 1'b1;
      end
      if (rst_at == c) begin
        reset_i = 1'b1;
        step();
        req_valid_i = 1'b1;
        exp_quiet(1'b0);
        e_chk_resp = 1'b1;
        e_rdata    = 64'd0;
        e_err      = 1'b0;
        step();
        reset_i     = 1'b0;
        req_valid_i = 1'b0;
        exp_quiet(1'b1);
        e_chk_resp = 1'b1;
        return;
      end
    end

    for (int s = 0; s <= stall; s++) begin
      step();
      resp_ready_i = (s == stall);
      req_valid_i  = 1'($urandom_range(0, 1));
      exp_quiet(1'b0);
      e_resp_valid = 1'b1;
      e_chk_resp   = 1'b1;
      e_rdata      = exp_rd;
      e_err        = err;
      if (s == 0 && lit_kind == 1) begin
        #1;
        chk("lit_rdata", resp_rdata_o, lit);
      end
    end
  endtask

  initial begin
    logic [2:0]  f3;
    logic        we;
    int          rst_at;
    reset_i      = 1'b1;
    req_valid_i  = 1'b0;
    req_we_i     = 1'b0;
    req_funct3_i = 3'd0;
    req_addr_i   = '0;
    req_wdata_i  = 64'd0;
    resp_ready_i = 1'b0;
    for (int i = 0; i < NENT; i++) mem_arr[i] = {$urandom, $urandom};
    mem_arr[0] = 64'h1111111111111111;
    mem_arr[1] = 64'h00000000000080F0;
    mem_arr[2] = 64'h8877665544332211;
    mem_arr[3] = 64'hF0E0D0C0B0A09080;
    mem_arr[5] = 64'h0123456789ABCDEF;
    for (int i = 0; i < NENT; i++) mdl[i] = mem_arr[i];

    step();
    exp_quiet(1'b0);
    e_chk_resp = 1'b1;
    e_rdata    = 64'd0;
    e_err      = 1'b0;
    chk_en     = 1'b1;
    step();
    reset_i = 1'b0;
    exp_quiet(1'b1);
    e_chk_resp = 1'b1;

    run_txn(1'b0, 3'b011, W'(16), 64'd0, 0, 0, 1, 64'h8877665544332211);
    run_txn(1'b0, 3'b000, W'(8), 64'd0, 0, 0, 1, 64'hFFFFFFFFFFFFFFF0);
    run_txn(1'b0, 3'b100, W'(9), 64'd0, 1, 0, 1, 64'h0000000000000080);
    run_txn(1'b0, 3'b001, W'(8), 64'd0, 0, 0, 1, 64'hFFFFFFFFFFFF80F0);
    run_txn(1'b1, 3'b001, W'(2), 64'hABCD, 0, 0, 2, 64'h11111111ABCD1111);
    run_txn(1'b0, 3'b011, W'(0), 64'd0, 0, 0, 1, 64'h11111111ABCD1111);
`ifdef DMEM_LSU_MISALIGN_TRAP_EN
    run_txn(1'b0, 3'b010, W'(30), 64'd0, 0, 0, 1, 64'd0);
`else
    run_txn(1'b0, 3'b010, W'(30), 64'd0, 0, 0, 1, 64'hFFFFFFFFF0E0D0C0);
`endif
    run_txn(1'b0, 3'b011, W'(16), 64'd0, 5, 0, 1, 64'h8877665544332211);
    idle(2);
    run_txn(1'b1, 3'b000, W'(41), 64'h5A, 0, 1, 0, 64'd0);
    chk("rst_entry_unchanged", mem_arr[5], 64'h0123456789ABCDEF);
    run_txn(1'b0, 3'b011, W'(40), 64'd0, 0, 0, 1, 64'h0123456789ABCDEF);
    run_txn(1'b1, 3'b010, W'(44), 64'h77665544, 0, 2, 0, 64'd0);
    run_txn(1'b0, 3'b011, W'(40), 64'd0, 0, 0, 1, 64'h7766554489ABCDEF);
    run_txn(1'b1, 3'b100, W'(24), 64'h1, 0, 0, 1, 64'd0);
    run_txn(1'b0, 3'b111, W'(24), 64'd0, 2, 0, 1, 64'd0);
    run_txn(1'b1, 3'b011, W'(56), 64'hDEADBEEFCAFEF00D, 0, 0, 0, 64'd0);
    run_txn(1'b0, 3'b110, W'(60), 64'd0, 0, 0, 1, 64'h00000000DEADBEEF);

    for (int t = 0; t < 300; t++) begin
      we = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      rst_at = 0;
      if (we && !f3[2] && f3[1:0] != 2'b11 && $urandom_range(0, 19) == 0)
        rst_at = int'($urandom_range(1, 2));
      run_txn(we, f3, W'($urandom), {$urandom, $urandom}, int'($urandom_range(0, 3)), rst_at, 0, 64'd0);
      if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 2)));
    end
    idle(2);
    chk_en = 1'b0;

    for (int i = 0; i < NENT; i++) chk($sformatf("mem_entry_%0d", i), mem_arr[i], mdl[i]);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
